seg_value_formatter: RTL

//  Converts a binary value into per-digit 5-bit codes for the seven-segment decoder array (one decoder per HEX digit).

---
 rtl/seg_value_formatter_if.sv | 24 ++
 rtl/seg_value_formatter.sv | 116 +++++++++++
 2 files changed

// File: rtl/seg_value_formatter_if.sv
// Request/result bundle for seg_value_formatter. The master side presents
// values for display, and the slave side returns the per-digit codes.
interface seg_value_formatter_if #(
  parameter int NUM_DIGITS = 6,
  parameter int IN_WIDTH   = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     value;
  logic                    dec_mode;
  logic [5*NUM_DIGITS-1:0] digits;
  logic                    out_valid;
  logic                    overflow;

  modport master (
    output in_valid, value, dec_mode,
    input  in_ready, digits, out_valid, overflow
  );

  modport slave (
    input  in_valid, value, dec_mode,
    output in_ready, digits, out_valid, overflow
  );
endinterface

// File: rtl/seg_value_formatter.sv
// Binary to seven-segment digit codes: hex nibble split or sequential double-dabble.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg_value_formatter #(
  parameter int NUM_DIGITS = 6,
  parameter int IN_WIDTH   = 20
) (
  input logic                clk,
  input logic                rst,
  seg_value_formatter_if.slave bus
);
  // ceil(IN_WIDTH*log10(2) + 1) decimal digits, in fixed point.
  localparam int BCD_DIGITS = (IN_WIDTH * 30103 + 199999) / 100000;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SRC_N      = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int SRC_W      = 4 * SRC_N;
  localparam int CNT_W      = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IN_WIDTH-1:0]     val;
  logic [BCD_W-1:0]        bcd;
  logic                    mode;
  logic [5*NUM_DIGITS-1:0] digits_q;
  logic                    overflow_q;
  logic                    out_valid_q;

  logic [BCD_W-1:0]        bcd_adj;
  logic [SRC_W-1:0]        src;
  logic                    ovf_next;
  logic [5*NUM_DIGITS-1:0] digits_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    seen_nz;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Both modes reduce to a nibble vector; any nonzero nibble past the display is overflow.
  always_comb begin
    src = '0;
    if (mode) src[BCD_W-1:0]    = bcd;
    else      src[IN_WIDTH-1:0] = val;

    ovf_next = 1'b0;
    for (int i = NUM_DIGITS; i < SRC_N; i++) begin
      if (src[4*i +: 4] != 4'd0) ovf_next = 1'b1;
    end

    digits_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_next[5*i +: 5] = {1'b0, src[4*i +: 4]};
    end
`ifdef LEADING_ZERO_BLANK_EN
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (src[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      else if (!seen_nz)         digits_next[5*i +: 5] = 5'h1F;
    end
`endif
    if (ovf_next) digits_next = {NUM_DIGITS{5'h0E}};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      val         <= '0;
      bcd         <= '0;
      mode        <= 1'b0;
      digits_q    <= {NUM_DIGITS{5'h1F}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            val   <= bus.value;
            mode  <= bus.dec_mode;
            bcd   <= '0;
            cnt   <= CNT_W'(IN_WIDTH);
            state <= bus.dec_mode ? S_CONV : S_DONE;
          end
        end
        S_CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], val[IN_WIDTH-1]};
          val <= {val[IN_WIDTH-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          digits_q    <= digits_next;
          overflow_q  <= ovf_next;
          out_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.digits    = digits_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;
endmodule
